// File: rtl/util_io_test_seq.sv
// Run-level sequencer for the util_io_test loopback tester: steps four half-bank
// phases per pass, pulses clear, settles, then accumulates a sticky fail map.
module util_io_test_seq #(
  parameter int unsigned IO_WIDTH       = 32,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned OBSERVE_CYCLES = 2048,
  parameter int unsigned CLR_CYCLES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         cfg_pass_count,
  input  logic [IO_WIDTH-1:0] cfg_pattern,
  input  logic [31:0]         cfg_baud_div,
  output logic                test_en,
  output logic                test_clr,
  output logic                test_baud_load,
  output logic [31:0]         test_baud_div,
  output logic [IO_WIDTH-1:0] test_force_default,
  output logic [IO_WIDTH-1:0] test_io_default,
  input  logic [IO_WIDTH-1:0] test_state,
  input  logic                test_state_valid,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [1:0]          phase,
  output logic [15:0]         pass_idx,
  output logic [IO_WIDTH-1:0] fail_map,
  output logic [3:0]          fail_phase,
  output logic                fail
);

  localparam int unsigned HALF = IO_WIDTH / 2;
  localparam logic [IO_WIDTH-1:0] LO_MASK = {{(IO_WIDTH - HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [IO_WIDTH-1:0] HI_MASK = ~LO_MASK;
  localparam logic [31:0] CLR_LOAD    = 32'(CLR_CYCLES - 1);
  localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] OBS_LOAD    = 32'(OBSERVE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SETTLE, S_OBSERVE, S_NEXT, S_DONE
  } state_t;

  state_t              state;
  logic [31:0]         cnt;
  logic [15:0]         pass_total;
  logic [IO_WIDTH-1:0] pattern;
  logic [16:0]         pass_next;

  // Inactive half is forced; odd phases exercise the high half.
  function automatic logic [IO_WIDTH-1:0] force_of(input logic [1:0] ph);
    return ph[0] ? LO_MASK : HI_MASK;
  endfunction

  function automatic logic [IO_WIDTH-1:0] default_of(input logic [1:0] ph,
                                                     input logic [IO_WIDTH-1:0] pat);
    return ph[1] ? ~pat : pat;
  endfunction

  assign pass_next = {1'b0, pass_idx} + 17'd1;
  assign fail      = |fail_map;

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= '0;
      pass_total         <= '0;
      pattern            <= '0;
      test_en            <= 1'b0;
      test_clr           <= 1'b0;
      test_baud_load     <= 1'b0;
      test_baud_div      <= '0;
      test_force_default <= '1;
      test_io_default    <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      aborted            <= 1'b0;
      phase              <= '0;
      pass_idx           <= '0;
      fail_map           <= '0;
      fail_phase         <= '0;
    end else begin
      test_baud_load <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      if (state != S_IDLE && abort) begin
        state    <= S_IDLE;
        aborted  <= 1'b1;
        busy     <= 1'b0;
        test_en  <= 1'b0;
        test_clr <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              pattern       <= cfg_pattern;
              pass_total    <= cfg_pass_count;
              test_baud_div <= cfg_baud_div;
              fail_map      <= '0;
              fail_phase    <= '0;
              pass_idx      <= '0;
              phase         <= '0;
              busy          <= 1'b1;
              if (cfg_pass_count == 16'd0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state              <= S_SETUP;
                cnt                <= CLR_LOAD;
                test_en            <= 1'b1;
                test_clr           <= 1'b1;
                test_baud_load     <= 1'b1;
                test_force_default <= force_of(2'd0);
                test_io_default    <= default_of(2'd0, cfg_pattern);
              end
            end
          end
          S_SETUP: begin
            if (cnt == 32'd0) begin
              state    <= S_SETTLE;
              cnt      <= SETTLE_LOAD;
              test_clr <= 1'b0;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          S_SETTLE: begin
            if (cnt == 32'd0) begin
              state <= S_OBSERVE;
              cnt   <= OBS_LOAD;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          S_OBSERVE: begin
            if (test_state_valid) begin
              fail_map <= fail_map | test_state;
              if (|test_state) fail_phase[phase] <= 1'b1;
            end
            if (cnt == 32'd0) begin
              state <= S_NEXT;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 32'd1;
            end
          end
          S_NEXT: begin
            if (phase != 2'd3) begin
              state              <= S_SETUP;
              cnt                <= CLR_LOAD;
              test_clr           <= 1'b1;
              phase              <= phase + 2'd1;
              test_force_default <= force_of(phase + 2'd1);
              test_io_default    <= default_of(phase + 2'd1, pattern);
            end else if (pass_next < {1'b0, pass_total}) begin
              state              <= S_SETUP;
              cnt                <= CLR_LOAD;
              test_clr           <= 1'b1;
              phase              <= 2'd0;
              pass_idx           <= pass_idx + 16'd1;
              test_force_default <= force_of(2'd0);
              test_io_default    <= default_of(2'd0, pattern);
            end else begin
              state   <= S_DONE;
              done    <= 1'b1;
              test_en <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_util_io_test_seq.sv
// Bench for util_io_test_seq: table of directed runs, cycle-exact reference runs
// with random stimulus, and hand sequences for abort, held start and reset.
module tb_util_io_test_seq;

  localparam int unsigned W   = 32;
  localparam int unsigned SET = 16;
  localparam int unsigned OBS = 32;
  localparam int unsigned CLR = 2;
  localparam int L = CLR + SET + OBS + 1;
  localparam logic [31:0] LO = 32'h0000ffff;
  localparam logic [31:0] HI = 32'hffff0000;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [15:0]   cfg_pass_count;
  logic [W-1:0]  cfg_pattern;
  logic [31:0]   cfg_baud_div;
  logic          test_en, test_clr, test_baud_load;
  logic [31:0]   test_baud_div;
  logic [W-1:0]  test_force_default, test_io_default, test_state;
  logic          test_state_valid;
  logic          busy, done, aborted;
  logic [1:0]    phase;
  logic [15:0]   pass_idx;
  logic [W-1:0]  fail_map;
  logic [3:0]    fail_phase;
  logic          fail;

  always #5 clk = ~clk;

  util_io_test_seq #(
    .IO_WIDTH(W), .SETTLE_CYCLES(SET), .OBSERVE_CYCLES(OBS), .CLR_CYCLES(CLR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pass_count(cfg_pass_count), .cfg_pattern(cfg_pattern), .cfg_baud_div(cfg_baud_div),
    .test_en(test_en), .test_clr(test_clr), .test_baud_load(test_baud_load),
    .test_baud_div(test_baud_div), .test_force_default(test_force_default),
    .test_io_default(test_io_default), .test_state(test_state),
    .test_state_valid(test_state_valid), .busy(busy), .done(done), .aborted(aborted),
    .phase(phase), .pass_idx(pass_idx), .fail_map(fail_map), .fail_phase(fail_phase),
    .fail(fail)
  );

  typedef struct packed {
    logic        en, clr, bl;
    logic [31:0] bdiv;
    logic [31:0] frc, iod;
    logic        busy, done, ab;
    logic [1:0]  ph;
    logic [15:0] pi;
    logic [31:0] fm;
    logic [3:0]  fp;
    logic        fl;
  } obs_t;

  typedef struct {
    int          p;
    logic [31:0] pat, baud;
    int          done_cyc, loads, en_cyc;
    logic [31:0] f1, i1, f2, i2;
  } tv_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state that persists between runs
  logic [31:0] m_force, m_io, m_bdiv, m_fm;
  logic [3:0]  m_fp;
  logic [1:0]  m_phase;
  logic [15:0] m_pass;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic obs_t cur();
    obs_t o;
    o.en = test_en; o.clr = test_clr; o.bl = test_baud_load; o.bdiv = test_baud_div;
    o.frc = test_force_default; o.iod = test_io_default;
    o.busy = busy; o.done = done; o.ab = aborted; o.ph = phase; o.pi = pass_idx;
    o.fm = fail_map; o.fp = fail_phase; o.fl = fail;
    return o;
  endfunction

  task automatic do_reset(input string name);
    obs_t e;
    rst = 1'b1;
    tick();
    m_force = '1; m_io = '0; m_bdiv = '0; m_fm = '0; m_fp = '0; m_phase = '0; m_pass = '0;
    e = '0;
    e.frc = '1;
    chk(name, 256'(cur()), 256'(e));
    rst = 1'b0;
  endtask

  // Whole run checked every cycle against a timeline computed from n alone
  task automatic run_model(input int p, input logic [31:0] pat, input logic [31:0] baud,
                           input int abort_at, input bit hold, input int mode);
    obs_t        e;
    int          last, stop, k, w;
    bit          obsv;
    logic [31:0] st;
    logic        vl;
    last = (p == 0) ? 1 : 4 * p * L + 1;
    stop = (abort_at != 0) ? abort_at + 2 : last + 2;
    cfg_pass_count = 16'(p); cfg_pattern = pat; cfg_baud_div = baud;
    start = 1'b1; abort = 1'b0; test_state = '0; test_state_valid = 1'b0;
    tick();
    m_fm = '0; m_fp = '0; m_phase = '0; m_pass = '0; m_bdiv = baud;
    for (int n = 1; n <= stop; n++) begin
      e = '0;
      obsv = 1'b0;
      k = (n - 1) / L;
      w = (n - 1) % L;
      if (abort_at != 0 && n > abort_at) begin
        e.ab = (n == abort_at + 1);
      end else if (n < last) begin
        m_phase = 2'(k % 4);
        m_pass  = 16'(k / 4);
        m_force = m_phase[0] ? LO : HI;
        m_io    = m_phase[1] ? ~pat : pat;
        e.en = 1'b1; e.clr = (w < CLR); e.bl = (n == 1); e.busy = 1'b1;
        obsv = (w >= CLR + SET) && (w < CLR + SET + OBS);
      end else if (n == last) begin
        e.busy = 1'b1; e.done = 1'b1;
      end
      e.bdiv = m_bdiv; e.frc = m_force; e.iod = m_io; e.ph = m_phase; e.pi = m_pass;
      e.fm = m_fm; e.fp = m_fp; e.fl = |m_fm;
      chk($sformatf("run p=%0d cyc%0d", p, n), 256'(cur()), 256'(e));
      case (mode)
        1: begin
          vl = 1'b1;
          st = (k == 6 && w == CLR + SET + 5) ? 32'h00000100 :
               (w == CLR + 3) ? 32'hdeadbeef : 32'h0;
        end
        2: begin
          vl = 1'b1;
          st = (k == 0 && w == CLR + SET + 1) ? 32'h00000008 : 32'h0;
        end
        default: begin
          vl = 1'($urandom_range(0, 1));
          if (obsv) st = ($urandom_range(0, 24) == 0) ? (32'd1 << $urandom_range(0, 31)) : 32'h0;
          else      st = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
        end
      endcase
      start = hold && (n < last) && (abort_at == 0 || n < abort_at);
      abort = (n == abort_at);
      test_state = st;
      test_state_valid = vl;
      if (obsv && vl && n != abort_at) begin
        m_fm = m_fm | st;
        if (st != 32'h0) m_fp[m_phase] = 1'b1;
      end
      tick();
    end
    start = 1'b0; abort = 1'b0; test_state = '0; test_state_valid = 1'b0;
  endtask

  initial begin
    tv_t         tbl[3];
    int          dc, bl, en_c;
    logic [31:0] f1, i1, f2, i2;

    tbl[0] = '{p:1, pat:32'h0000ffff, baud:32'd868, done_cyc:205, loads:1, en_cyc:204,
               f1:32'h0000ffff, i1:32'h0000ffff, f2:32'hffff0000, i2:32'hffff0000};
    tbl[1] = '{p:2, pat:32'h12345678, baud:32'd27, done_cyc:409, loads:1, en_cyc:408,
               f1:32'h0000ffff, i1:32'h12345678, f2:32'hffff0000, i2:32'hedcba987};
    tbl[2] = '{p:0, pat:32'hcafef00d, baud:32'd5, done_cyc:1, loads:0, en_cyc:0,
               f1:32'h0, i1:32'h0, f2:32'h0, i2:32'h0};

    start = 1'b0; abort = 1'b0; cfg_pass_count = '0; cfg_pattern = '0; cfg_baud_div = '0;
    test_state = '0; test_state_valid = 1'b0;
    do_reset("reset_state");

    // Directed all-pass runs: loopback reports no mismatches
    for (int i = 0; i < 3; i++) begin
      cfg_pass_count = 16'(tbl[i].p); cfg_pattern = tbl[i].pat; cfg_baud_div = tbl[i].baud;
      test_state = '0; test_state_valid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      dc = -1; bl = 0; en_c = 0; f1 = '0; i1 = '0; f2 = '0; i2 = '0;
      for (int n = 1; n <= 2000 && dc < 0; n++) begin
        if (done) dc = n;
        if (test_baud_load) bl++;
        if (test_en) en_c++;
        if (n == 1 + L + CLR + SET)     begin f1 = test_force_default; i1 = test_io_default; end
        if (n == 1 + 2 * L + CLR + SET) begin f2 = test_force_default; i2 = test_io_default; end
        tick();
      end
      chk($sformatf("tbl%0d done_cycle", i), 256'(dc), 256'(tbl[i].done_cyc));
      chk($sformatf("tbl%0d baud_loads", i), 256'(bl), 256'(tbl[i].loads));
      chk($sformatf("tbl%0d en_cycles", i), 256'(en_c), 256'(tbl[i].en_cyc));
      chk($sformatf("tbl%0d busy_after", i), 256'(busy), 256'(1'b0));
      chk($sformatf("tbl%0d fail_map", i), 256'({fail_map, fail_phase, fail}), 256'(0));
      chk($sformatf("tbl%0d baud_div", i), 256'(test_baud_div), 256'(tbl[i].baud));
      if (tbl[i].p > 0) begin
        chk($sformatf("tbl%0d ph1_force", i), 256'(f1), 256'(tbl[i].f1));
        chk($sformatf("tbl%0d ph1_io", i), 256'(i1), 256'(tbl[i].i1));
        chk($sformatf("tbl%0d ph2_force", i), 256'(f2), 256'(tbl[i].f2));
        chk($sformatf("tbl%0d ph2_io", i), 256'(i2), 256'(tbl[i].i2));
      end
    end
    test_state_valid = 1'b0;
    do_reset("reset_after_table");

    // Injection in phase 2 of pass 1, plus discarded SETTLE injections every phase
    run_model(2, 32'h0f0f_3c3c, 32'd100, 0, 1'b0, 1);
    chk("inj fail_map", 256'(fail_map), 256'(32'h00000100));
    chk("inj fail_phase", 256'(fail_phase), 256'(4'b0100));
    chk("inj fail", 256'(fail), 256'(1'b1));

    // Abort in OBSERVE of phase 1 keeps results; next start clears them
    run_model(2, 32'h5555_aaaa, 32'd7, 1 + L + CLR + SET + 10, 1'b0, 2);
    chk("abort held fail_map", 256'(fail_map), 256'(32'h00000008));
    chk("abort held fail_phase", 256'(fail_phase), 256'(4'b0001));
    run_model(0, 32'h1, 32'd9, 0, 1'b1, 0);
    chk("restart clears", 256'({fail_map, fail_phase}), 256'(0));

    // Held start must not restart an active run
    run_model(1, 32'h89ab_cdef, 32'd3, 0, 1'b1, 0);

    // Random runs with random abort points
    for (int r = 0; r < 6; r++) begin
      int p, ab;
      p  = $urandom_range(0, 2);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (p == 0) ? 1 : 4 * p * L + 1) : 0;
      run_model(p, $urandom, $urandom, ab, 1'($urandom_range(0, 1)), 0);
    end

    // Reset in the middle of SETTLE
    cfg_pass_count = 16'd1; cfg_pattern = 32'h0000ffff; cfg_baud_div = 32'd50;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (CLR + 3) tick();
    chk("pre_reset busy", 256'({busy, test_en, test_clr}), 256'(3'b110));
    do_reset("reset_mid_settle");
    tick();
    chk("post_reset idle", 256'({busy, test_en, test_force_default}), 256'({2'b00, 32'hffffffff}));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/util_io_test_seq.md
# util_io_test_seq

Run-level sequencer for the `util_io_test` IO loopback tester. On a start request it latches a pattern and baud divisor, then steps the tester through four half-bank phases per pass. Each phase programs `force_default`/`io_default`, pulses `clr`, waits a settle window and accumulates the tester's `state` over an observe window. It reports a sticky per-bit fail map and per-phase fail flags to a register block or host.

## Interface
- `IO_WIDTH`, 32: IO bits under test; even, ≥2; `LO_MASK` = low `IO_WIDTH/2` bits set, `HI_MASK` = `~LO_MASK`.
- `SETTLE_CYCLES`, 1024: cycles from end of clear to start of observation; ≥1.
- `OBSERVE_CYCLES`, 2048: cycles `state` is sampled per phase; ≥1.
- `CLR_CYCLES`, 2: width of `test_clr` pulse; ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin run; sampled only in IDLE.
- `abort`  in  1  stop run; priority over everything except `rst`.
- `cfg_pass_count`  in  16  passes per run; latched at start.
- `cfg_pattern`  in  `IO_WIDTH`  default pattern; latched at start.
- `cfg_baud_div`  in  32  tester baud divisor; latched at start.
- `test_en`  out  1  to tester `en`.
- `test_clr`  out  1  to tester `clr`.
- `test_baud_load`  out  1  to tester `baud_load`.
- `test_baud_div`  out  32  to tester `baud_div`.
- `test_force_default`  out  `IO_WIDTH`  to tester `force_default`.
- `test_io_default`  out  `IO_WIDTH`  to tester `io_default`.
- `test_state`  in  `IO_WIDTH`  tester mismatch bits (1 = error).
- `test_state_valid`  in  1  qualifies `test_state`.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse: run completed normally.
- `aborted`  out  1  one-cycle pulse: run stopped by `abort`.
- `phase`  out  2  current phase index.
- `pass_idx`  out  16  current pass, 0-based.
- `fail_map`  out  `IO_WIDTH`  sticky OR of valid `test_state` across run.
- `fail_phase`  out  4  bit k set if any error seen in phase k.
- `fail`  out  1  `|fail_map`.

## Operation
- States: IDLE, SETUP, SETTLE, OBSERVE, NEXT, DONE.
- IDLE: `start`=1 latches cfg inputs, clears `fail_map`/`fail_phase`, sets `pass_idx`=0 and `phase`=0. If `cfg_pass_count`=0, go to DONE; otherwise go to SETUP.
- Phase table:
  - 0: active=LO, default=pattern.
  - 1: active=HI, default=pattern.
  - 2: active=LO, default=~pattern.
  - 3: active=HI, default=~pattern.
  - `test_force_default` = ~active mask; `test_io_default` = default value. Both are registered and updated on entry to SETUP.
- SETUP: `CLR_CYCLES` cycles with `test_clr`=1, then SETTLE. `test_baud_load` pulses in the first SETUP cycle of the run only.
- SETTLE: `SETTLE_CYCLES` cycles, then OBSERVE.
- OBSERVE: `OBSERVE_CYCLES` cycles. Each cycle with `test_state_valid`=1 ORs `test_state` into `fail_map`. If `test_state` is nonzero, `fail_phase[phase]` is also set.
- NEXT: 1 cycle; advance the phase.
  - `phase`<3: increment `phase`, go to SETUP.
  - `phase`=3 and `pass_idx`<`cfg_pass_count`-1: `phase`=0, increment `pass_idx`, go to SETUP.
  - Otherwise: go to DONE.
- DONE: 1 cycle with `done`=1, then IDLE.
- `test_en`=1 in SETUP, SETTLE, OBSERVE and NEXT; it does not drop between phases.
- `abort` in any non-IDLE state: next state is IDLE, `aborted`=1 for one cycle, `test_en`=0 and `test_clr`=0. Fail results are kept.
- `start` while busy is ignored. `abort` in IDLE is ignored.
- Cycle counter is 32 bit and reloads on every state entry. `pass_idx` never wraps because `cfg_pass_count` ≤ 65535.

## Timing
- Reset values:
  - `test_en`, `test_clr`, `test_baud_load`, `busy`, `done`, `aborted`, `fail`: 0.
  - `test_baud_div`, `phase`, `pass_idx`, `fail_map`, `fail_phase`: 0.
  - `test_force_default`: all ones. `test_io_default`: 0.
- Reset mid-run returns the block to IDLE with all outputs at these values on the next cycle.
- `start` sampled at edge 0: `busy`=1 and `test_clr`=1 from cycle 1.
- Phase length = `CLR_CYCLES`+`SETTLE_CYCLES`+`OBSERVE_CYCLES`+1 = L.
- `done`=1 in cycle 1+4·P·L, where P = `cfg_pass_count`. `busy`=0 from the following cycle.
- Zero-pass run: `done`=1 in cycle 1, `test_en` never asserted.
- `test_state` is sampled only in OBSERVE; valid data during SETUP, SETTLE or NEXT is discarded.
- `fail` is registered and trails the `fail_map` update by 0 cycles (combinational from the registered map).

## Test plan
- Loopback with `io_i` = `io_o` registered, P=1, pattern=32'h0000ffff, SETTLE=16, OBSERVE=32 -> `done` at cycle 1+4·51=205, `fail_map`=0, `fail_phase`=0, `test_baud_load` exactly 1 pulse.
- Same run, phase 1 observed -> `test_force_default`=32'h0000ffff, `test_io_default`=32'h0000ffff. Phase 2 observed -> `test_force_default`=32'hffff0000, `test_io_default`=32'hffff0000.
- Inject `test_state`=32'h00000100 with valid for one cycle in phase 2 of pass 1, P=2 -> `fail_map`=32'h00000100, `fail_phase`=4'b0100, `fail`=1. Injections during SETTLE leave `fail_map`=0.
- `abort` in OBSERVE of phase 1 -> `aborted` pulse next cycle, `test_en`=0, no `done`, results held. A new `start` clears the results.
- `cfg_pass_count`=0 -> `done` at cycle 1, `test_en` never 1. `start` held during a run does not restart it.
- `rst` asserted mid-SETTLE -> next cycle all outputs at reset values, `test_force_default` all ones.
